// File: rtl/shift_detect.sv
// Bidirectional serial shift register that flags each shift producing PATTERN.
// It also keeps a saturating count of those match pulses.
module shift_detect #(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             a,
    input  logic             clr,
    output logic [WIDTH-1:0] r,
    output logic             valid,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [FILL_W-1:0] fill_r;
    logic [WIDTH-1:0]  next_r_s;
    logic [FILL_W-1:0] next_fill_s;
    logic              next_match_s;

    // Next-state of a shift, so match can be judged against the value r is about to take.
    always_comb begin
        next_r_s     = r;
        next_fill_s  = fill_r;
        next_match_s = 1'b0;
        if (dir) begin
            next_r_s = {a, r[WIDTH-1:1]};
        end else begin
            next_r_s = {r[WIDTH-2:0], a};
        end
        if (fill_r == FILL_FULL) begin
            next_fill_s = fill_r;
        end else begin
            next_fill_s = fill_r + FILL_W'(1);
        end
        next_match_s = (next_r_s == PATTERN) && (next_fill_s == FILL_FULL);
    end

    // Shift register, fill tracking, match pulse and saturating counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            fill_r    <= '0;
            valid     <= 1'b0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else if (clr) begin
            r         <= '0;
            fill_r    <= '0;
            valid     <= 1'b0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else if (en) begin
            r      <= next_r_s;
            fill_r <= next_fill_s;
            valid  <= (next_fill_s == FILL_FULL);
            match  <= next_match_s;
            if (next_match_s && (match_cnt != CNT_MAX)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end else begin
                match_cnt <= match_cnt;
            end
        end else begin
            match <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_detect.sv
// Directed bench for shift_detect: default instance plus a PATTERN=0, CNT_W=2 instance.
module tb_shift_detect;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       a = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] r1, r2;
    logic       v1, v2, m1, m2;
    logic [7:0] c1;
    logic [1:0] c2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] r1; logic v1; logic m1; logic [7:0] c1;
        logic [3:0] r2; logic v2; logic m2; logic [1:0] c2;
    } exp_t;
    exp_t q[$];

    // model state
    logic [3:0] mr1, mr2;
    int         mf1, mf2;
    logic       mm1, mm2;
    int         mc1, mc2;

    shift_detect dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .a(a), .clr(clr),
        .r(r1), .valid(v1), .match(m1), .match_cnt(c1)
    );

    shift_detect #(.WIDTH(4), .PATTERN(4'b0000), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .a(a), .clr(clr),
        .r(r2), .valid(v2), .match(m2), .match_cnt(c2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        mr1 = 4'b0000; mf1 = 0; mm1 = 1'b0; mc1 = 0;
        mr2 = 4'b0000; mf2 = 0; mm2 = 1'b0; mc2 = 0;
    endtask

    task automatic model_shift(input logic ai, input logic d,
                               inout logic [3:0] mr, inout int mf, inout logic mm,
                               inout int mc, input logic [3:0] pat, input int cmax);
        if (d) mr = {ai, mr[3:1]};
        else   mr = {mr[2:0], ai};
        if (mf < 4) mf = mf + 1;
        mm = (mr == pat) && (mf == 4);
        if (mm && mc < cmax) mc = mc + 1;
    endtask

    task automatic compare_all(input string tag);
        exp_t e;
        e = q.pop_front();
        check({tag, ".r1"}, 32'(r1), 32'(e.r1));
        check({tag, ".v1"}, 32'(v1), 32'(e.v1));
        check({tag, ".m1"}, 32'(m1), 32'(e.m1));
        check({tag, ".c1"}, 32'(c1), 32'(e.c1));
        check({tag, ".r2"}, 32'(r2), 32'(e.r2));
        check({tag, ".v2"}, 32'(v2), 32'(e.v2));
        check({tag, ".m2"}, 32'(m2), 32'(e.m2));
        check({tag, ".c2"}, 32'(c2), 32'(e.c2));
    endtask

    // Drive one cycle of stimulus, push the model's expectation, then compare after the edge.
    task automatic step(input string tag, input logic e, input logic d,
                        input logic ai, input logic c);
        exp_t x;
        @(negedge clk);
        en = e; dir = d; a = ai; clr = c;
        if (c) begin
            model_zero();
        end else if (e) begin
            model_shift(ai, d, mr1, mf1, mm1, mc1, 4'b1011, 255);
            model_shift(ai, d, mr2, mf2, mm2, mc2, 4'b0000, 3);
        end else begin
            mm1 = 1'b0; mm2 = 1'b0;
        end
        x.r1 = mr1; x.v1 = (mf1 == 4); x.m1 = mm1; x.c1 = 8'(mc1);
        x.r2 = mr2; x.v2 = (mf2 == 4); x.m2 = mm2; x.c2 = 2'(mc2);
        q.push_back(x);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        #2;
        en = 1'b0; clr = 1'b0;
        rst_n = 1'b0;
        #1;
        model_zero();
        check({tag, ".r1"}, 32'(r1), 32'd0);
        check({tag, ".v1"}, 32'(v1), 32'd0);
        check({tag, ".m1"}, 32'(m1), 32'd0);
        check({tag, ".c1"}, 32'(c1), 32'd0);
        check({tag, ".c2"}, 32'(c2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] seq;
        model_zero();
        do_reset("rst0");

        // left shift 1,0,1,1 then overlap 0,1,1
        step("l1", 1'b1, 1'b0, 1'b1, 1'b0); check("l1.r", 32'(r1), 32'h1);
        step("l2", 1'b1, 1'b0, 1'b0, 1'b0); check("l2.r", 32'(r1), 32'h2);
        step("l3", 1'b1, 1'b0, 1'b1, 1'b0); check("l3.m", 32'(m1), 32'd0);
        step("l4", 1'b1, 1'b0, 1'b1, 1'b0);
        check("l4.r", 32'(r1), 32'hb); check("l4.m", 32'(m1), 32'd1); check("l4.c", 32'(c1), 32'd1);
        step("o1", 1'b1, 1'b0, 1'b0, 1'b0); check("o1.r", 32'(r1), 32'h6); check("o1.m", 32'(m1), 32'd0);
        step("o2", 1'b1, 1'b0, 1'b1, 1'b0); check("o2.r", 32'(r1), 32'hd);
        step("o3", 1'b1, 1'b0, 1'b1, 1'b0);
        check("o3.m", 32'(m1), 32'd1); check("o3.c", 32'(c1), 32'd2);

        // clr has priority over en
        step("clr", 1'b1, 1'b0, 1'b1, 1'b1);
        check("clr.r", 32'(r1), 32'h0); check("clr.v", 32'(v1), 32'd0); check("clr.c", 32'(c1), 32'd0);

        // right shift 1,1,0,1 then hold
        do_reset("rst1");
        step("r1", 1'b1, 1'b1, 1'b1, 1'b0); check("r1.r", 32'(r1), 32'h8);
        step("r2", 1'b1, 1'b1, 1'b1, 1'b0); check("r2.r", 32'(r1), 32'hc);
        step("r3", 1'b1, 1'b1, 1'b0, 1'b0); check("r3.r", 32'(r1), 32'h6);
        step("r4", 1'b1, 1'b1, 1'b1, 1'b0); check("r4.m", 32'(m1), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, 1'b1, 1'b0, 1'b0);
            check("hold.r", 32'(r1), 32'hb); check("hold.m", 32'(m1), 32'd0);
        end

        // zero pattern gated by valid, counter saturates at 3
        do_reset("rst2");
        for (int i = 1; i <= 8; i++) begin
            step("z", 1'b1, 1'b0, 1'b0, 1'b0);
            check("z.m2", 32'(m2), (i >= 4) ? 32'd1 : 32'd0);
            if (i >= 4) check("z.c2", 32'(c2), (i == 4) ? 32'd1 : (i == 5) ? 32'd2 : 32'd3);
        end

        // async reset after two shifts, then fresh fill
        do_reset("rst3");
        step("a1", 1'b1, 1'b0, 1'b1, 1'b0);
        step("a2", 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset("rst4");
        seq = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            step("af", 1'b1, 1'b0, seq[i], 1'b0);
            check("af.m", 32'(m1), (i == 0) ? 32'd1 : 32'd0);
        end

        // mixed direction changes, gaps and occasional clears
        for (int i = 0; i < 60; i++) begin
            step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
